// File: rtl/sys_cmd_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sys_cmd_ctrl_if : rx byte / register-file / ALU / tx bundle of sys_cmd_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
interface sys_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0]   rx_data;
    logic                    rx_valid;
    logic                    rf_wr_en;
    logic                    rf_rd_en;
    logic [ADDR_WIDTH-1:0]   rf_addr;
    logic [DATA_WIDTH-1:0]   rf_wr_data;
    logic [DATA_WIDTH-1:0]   rf_rd_data;
    logic                    rf_rd_valid;
    logic                    alu_en;
    logic [FUN_WIDTH-1:0]    alu_fun;
    logic [2*DATA_WIDTH-1:0] alu_out;
    logic                    alu_out_valid;
    logic                    clk_gate_en;
    logic [DATA_WIDTH-1:0]   tx_data;
    logic                    tx_valid;
    logic                    tx_busy;

    // Controller side
    modport master (
        input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_busy,
        output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en,
               tx_data, tx_valid
    );

    // Peripheral side (register file, ALU, UART)
    modport slave (
        output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_busy,
        input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en,
               tx_data, tx_valid
    );
endinterface
`default_nettype wire

// File: rtl/sys_cmd_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sys_cmd_ctrl : command-frame decoder driving register file, ALU and tx path
// Rev 1.0
// ---------------------------------------------------------------------------
module sys_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic           clk,
    input  logic           rst,
    sys_cmd_ctrl_if.master io_bus
);
    localparam logic [DATA_WIDTH-1:0] c_CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] c_CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] c_CMD_OPS = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] c_CMD_ALU = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_OP_A, S_OP_B,
        S_ALU_FUN, S_ALU_WAIT, S_TX_LO, S_TX_LO_WT, S_TX_HI, S_TX_HI_WT
    } state_t;

    state_t                  r_state,     w_state;
    logic [ADDR_WIDTH-1:0]   r_addr,      w_addr;
    logic                    r_wr_en,     w_wr_en;
    logic                    r_rd_en,     w_rd_en;
    logic [DATA_WIDTH-1:0]   r_wr_data,   w_wr_data;
    logic                    r_alu_en,    w_alu_en;
    logic [FUN_WIDTH-1:0]    r_fun,       w_fun;
    logic                    r_gate,      w_gate;
    logic [DATA_WIDTH-1:0]   r_tx_data,   w_tx_data;
    logic                    r_tx_valid,  w_tx_valid;
    logic [2*DATA_WIDTH-1:0] r_result,    w_result;
    logic                    r_single,    w_single;
    logic                    r_busy_seen, w_busy_seen;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_wr_data   <= '0;
            r_alu_en    <= 1'b0;
            r_fun       <= '0;
            r_gate      <= 1'b0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_result    <= '0;
            r_single    <= 1'b0;
            r_busy_seen <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            r_wr_en     <= w_wr_en;
            r_rd_en     <= w_rd_en;
            r_wr_data   <= w_wr_data;
            r_alu_en    <= w_alu_en;
            r_fun       <= w_fun;
            r_gate      <= w_gate;
            r_tx_data   <= w_tx_data;
            r_tx_valid  <= w_tx_valid;
            r_result    <= w_result;
            r_single    <= w_single;
            r_busy_seen <= w_busy_seen;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_wr_data   = r_wr_data;
        w_alu_en    = 1'b0;
        w_fun       = r_fun;
        w_gate      = r_gate;
        w_tx_data   = r_tx_data;
        w_tx_valid  = r_tx_valid;
        w_result    = r_result;
        w_single    = r_single;
        w_busy_seen = r_busy_seen;
        case (r_state)
            S_IDLE: begin
                if (io_bus.rx_valid) begin
                    if (io_bus.rx_data == c_CMD_WR)       w_state = S_WR_ADDR;
                    else if (io_bus.rx_data == c_CMD_RD)  w_state = S_RD_ADDR;
                    else if (io_bus.rx_data == c_CMD_OPS) w_state = S_OP_A;
                    else if (io_bus.rx_data == c_CMD_ALU) begin
                        w_state = S_ALU_FUN;
                        w_gate  = 1'b1;
                    end
                end
            end
            S_WR_ADDR: if (io_bus.rx_valid) begin
                w_addr  = io_bus.rx_data[ADDR_WIDTH-1:0];
                w_state = S_WR_DATA;
            end
            S_WR_DATA: if (io_bus.rx_valid) begin
                w_wr_en   = 1'b1;
                w_wr_data = io_bus.rx_data;
                w_state   = S_IDLE;
            end
            S_RD_ADDR: if (io_bus.rx_valid) begin
                w_addr  = io_bus.rx_data[ADDR_WIDTH-1:0];
                w_rd_en = 1'b1;
                w_state = S_RD_WAIT;
            end
            S_RD_WAIT: if (io_bus.rf_rd_valid) begin
                w_result   = {{DATA_WIDTH{1'b0}}, io_bus.rf_rd_data};
                w_single   = 1'b1;
                w_tx_data  = io_bus.rf_rd_data;
                w_tx_valid = 1'b1;
                w_state    = S_TX_LO;
            end
            // Operands land in fixed register-file slots 0 (A) and 1 (B)
            S_OP_A: if (io_bus.rx_valid) begin
                w_wr_en   = 1'b1;
                w_addr    = '0;
                w_wr_data = io_bus.rx_data;
                w_state   = S_OP_B;
            end
            S_OP_B: if (io_bus.rx_valid) begin
                w_wr_en   = 1'b1;
                w_addr    = ADDR_WIDTH'(1);
                w_wr_data = io_bus.rx_data;
                w_gate    = 1'b1;
                w_state   = S_ALU_FUN;
            end
            S_ALU_FUN: if (io_bus.rx_valid) begin
                w_fun    = io_bus.rx_data[FUN_WIDTH-1:0];
                w_alu_en = 1'b1;
                w_state  = S_ALU_WAIT;
            end
            S_ALU_WAIT: if (io_bus.alu_out_valid) begin
                w_result   = io_bus.alu_out;
                w_single   = 1'b0;
                w_gate     = 1'b0;
                w_tx_data  = io_bus.alu_out[DATA_WIDTH-1:0];
                w_tx_valid = 1'b1;
                w_state    = S_TX_LO;
            end
            S_TX_LO, S_TX_HI: if (r_tx_valid && !io_bus.tx_busy) begin
                w_tx_valid  = 1'b0;
                w_busy_seen = 1'b0;
                w_state     = (r_state == S_TX_LO) ? S_TX_LO_WT : S_TX_HI_WT;
            end
            // The byte is only done once the transmitter has gone busy and idle again
            S_TX_LO_WT: begin
                if (io_bus.tx_busy) begin
                    w_busy_seen = 1'b1;
                end else if (r_busy_seen) begin
                    if (r_single) begin
                        w_state = S_IDLE;
                    end else begin
                        w_tx_data  = r_result[2*DATA_WIDTH-1:DATA_WIDTH];
                        w_tx_valid = 1'b1;
                        w_state    = S_TX_HI;
                    end
                end
            end
            S_TX_HI_WT: begin
                if (io_bus.tx_busy)   w_busy_seen = 1'b1;
                else if (r_busy_seen) w_state     = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign io_bus.rf_wr_en    = r_wr_en;
    assign io_bus.rf_rd_en    = r_rd_en;
    assign io_bus.rf_addr     = r_addr;
    assign io_bus.rf_wr_data  = r_wr_data;
    assign io_bus.alu_en      = r_alu_en;
    assign io_bus.alu_fun     = r_fun;
    assign io_bus.clk_gate_en = r_gate;
    assign io_bus.tx_data     = r_tx_data;
    assign io_bus.tx_valid    = r_tx_valid;
endmodule
`default_nettype wire

// File: tb/tb_sys_cmd_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sys_cmd_ctrl : frame-level model plus per-cycle output checks
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sys_cmd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    sys_cmd_ctrl_if bus ();
    sys_cmd_ctrl dut (.clk(clk), .rst(rst), .io_bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } ev_t;

    ev_t        exp_wr[$];
    ev_t        exp_rd[$];
    ev_t        exp_alu[$];
    int         exp_tx[$];
    logic [7:0] m_frame[$];
    int         m_wait = 0;        // 0 parsing, 1 read pending, 2 ALU pending, 3 sending
    int         m_gate_on = 0;
    int         m_gate_off = 0;

    int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0;
    int last_wr_addr = -1, last_wr_data = -1, last_rd_addr = -1, last_fun = -1;
    int tx_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk(input int c, input int a, input int d);
        ev_t e;
        e.cyc = c; e.addr = a; e.data = d;
        return e;
    endfunction

    function automatic int frame_len(input logic [7:0] c);
        case (c)
            8'hAA:   return 3;
            8'hBB:   return 2;
            8'hCC:   return 4;
            8'hDD:   return 2;
            default: return 0;
        endcase
    endfunction

    // Frame-level model: collect whole frames and derive the strobes they imply
    task automatic m_feed(input logic [7:0] b, input int c);
        int n;
        if (m_wait != 0) return;
        if (m_frame.size() == 0 && frame_len(b) == 0) return;
        m_frame.push_back(b);
        n = m_frame.size();
        case (m_frame[0])
            8'hAA: if (n == 3) exp_wr.push_back(mk(c + 1, int'(m_frame[1][3:0]), int'(m_frame[2])));
            8'hBB: if (n == 2) begin
                exp_rd.push_back(mk(c + 1, int'(m_frame[1][3:0]), 0));
                m_wait = 1;
            end
            8'hCC: begin
                if (n == 2) exp_wr.push_back(mk(c + 1, 0, int'(m_frame[1])));
                if (n == 3) begin
                    exp_wr.push_back(mk(c + 1, 1, int'(m_frame[2])));
                    m_gate_on  = c + 1;
                    m_gate_off = 32'h7fffffff;
                end
                if (n == 4) begin
                    exp_alu.push_back(mk(c + 1, int'(m_frame[3][3:0]), 0));
                    m_wait = 2;
                end
            end
            8'hDD: begin
                if (n == 1) begin
                    m_gate_on  = c + 1;
                    m_gate_off = 32'h7fffffff;
                end
                if (n == 2) begin
                    exp_alu.push_back(mk(c + 1, int'(m_frame[1][3:0]), 0));
                    m_wait = 2;
                end
            end
            default: ;
        endcase
        if (n == frame_len(m_frame[0])) m_frame.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        m_feed(b, cyc);
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic rd_resp(input logic [7:0] d);
        bus.rf_rd_data  = d;
        bus.rf_rd_valid = 1'b1;
        if (m_wait == 1) begin
            exp_tx.push_back(int'(d));
            m_wait = 3;
        end
        tick();
        bus.rf_rd_valid = 1'b0;
    endtask

    task automatic alu_resp(input logic [15:0] v);
        bus.alu_out       = v;
        bus.alu_out_valid = 1'b1;
        if (m_wait == 2) begin
            exp_tx.push_back(int'(v[7:0]));
            exp_tx.push_back(int'(v[15:8]));
            m_gate_off = cyc + 1;
            m_wait     = 3;
        end
        tick();
        bus.alu_out_valid = 1'b0;
    endtask

    // Transmitter: hold off with busy, accept, then go busy and idle again
    task automatic serve_tx(input int n, input bit inject);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            while (bus.tx_valid !== 1'b1 && t < 50) begin
                tick();
                t++;
            end
            if (t >= 50) begin
                chk("tx_valid timeout", 32'd0, 32'd1);
                return;
            end
            bus.tx_busy = 1'b1;
            for (int k = 0; k < 3; k++) if (inject) send(8'hAA); else tick();
            bus.tx_busy = 1'b0;
            tick();
            bus.tx_busy = 1'b1;
            for (int k = 0; k < 4; k++) if (inject && k == 1) send(8'h55); else tick();
            bus.tx_busy = 1'b0;
            tick();
        end
        idle(1);
        m_wait = 0;
    endtask

    ev_t e;
    int  dmy;
    bit  tx_pend = 1'b0, tx_seen1 = 1'b0, prev_hold = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            chk("clk_gate_en", 32'(bus.clk_gate_en), 32'(cyc >= m_gate_on && cyc < m_gate_off));

            if (bus.rf_wr_en === 1'b1) begin
                wr_cnt++;
                last_wr_addr = int'(bus.rf_addr);
                last_wr_data = int'(bus.rf_wr_data);
                if (exp_wr.size() == 0) chk("rf_wr_en unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr cycle", cyc, e.cyc);
                    chk("wr addr", 32'(bus.rf_addr), e.addr);
                    chk("wr data", 32'(bus.rf_wr_data), e.data);
                end
            end else if (exp_wr.size() != 0 && exp_wr[0].cyc <= cyc) begin
                chk("rf_wr_en missing", 32'd0, 32'd1);
                e = exp_wr.pop_front();
            end

            if (bus.rf_rd_en === 1'b1) begin
                rd_cnt++;
                last_rd_addr = int'(bus.rf_addr);
                if (exp_rd.size() == 0) chk("rf_rd_en unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_rd.pop_front();
                    chk("rd cycle", cyc, e.cyc);
                    chk("rd addr", 32'(bus.rf_addr), e.addr);
                end
            end else if (exp_rd.size() != 0 && exp_rd[0].cyc <= cyc) begin
                chk("rf_rd_en missing", 32'd0, 32'd1);
                e = exp_rd.pop_front();
            end

            if (bus.alu_en === 1'b1) begin
                alu_cnt++;
                last_fun = int'(bus.alu_fun);
                if (exp_alu.size() == 0) chk("alu_en unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_alu.pop_front();
                    chk("alu cycle", cyc, e.cyc);
                    chk("alu_fun", 32'(bus.alu_fun), e.addr);
                end
            end else if (exp_alu.size() != 0 && exp_alu[0].cyc <= cyc) begin
                chk("alu_en missing", 32'd0, 32'd1);
                e = exp_alu.pop_front();
            end

            if (bus.tx_valid === 1'b1) begin
                if (tx_pend) chk("tx_valid before busy 1->0", 32'd1, 32'd0);
                if (exp_tx.size() == 0) chk("tx_valid unexpected", 32'd1, 32'd0);
                else chk("tx_data", 32'(bus.tx_data), exp_tx[0]);
                if (bus.tx_busy === 1'b0) begin
                    if (exp_tx.size() != 0) dmy = exp_tx.pop_front();
                    tx_log.push_back(int'(bus.tx_data));
                    tx_pend   = 1'b1;
                    tx_seen1  = 1'b0;
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                end
            end else begin
                if (prev_hold) chk("tx_valid dropped before accept", 32'd0, 32'd1);
                prev_hold = 1'b0;
                if (tx_pend) begin
                    if (bus.tx_busy === 1'b1) tx_seen1 = 1'b1;
                    else if (tx_seen1)        tx_pend  = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_data = '0;       bus.rx_valid = 1'b0;
        bus.rf_rd_data = '0;    bus.rf_rd_valid = 1'b0;
        bus.alu_out = '0;       bus.alu_out_valid = 1'b0;
        bus.tx_busy = 1'b0;
        idle(2);
        chk("reset outputs", 32'({bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wr_data, bus.alu_en,
                                  bus.alu_fun, bus.clk_gate_en, bus.tx_data, bus.tx_valid}), 32'd0);
        rst = 1'b1;
        tick();

        // Write frame
        send(8'hAA); send(8'h05); send(8'h3C);
        idle(3);
        chk("write count", wr_cnt, 1);
        chk("write addr literal", last_wr_addr, 5);
        chk("write data literal", last_wr_data, 32'h3C);

        // Read frame with stray rx bytes and a stray ALU result while waiting
        send(8'hBB); send(8'h02);
        send(8'hCC); send(8'hDD);
        alu_resp(16'hFFFF);
        rd_resp(8'h7E);
        serve_tx(1, 1'b1);
        idle(2);
        chk("read count", rd_cnt, 1);
        chk("read addr literal", last_rd_addr, 2);
        chk("read tx count", tx_log.size(), 1);
        chk("read tx byte literal", tx_log[0], 32'h7E);

        // ALU frame with operands, stray read data while waiting
        send(8'hCC); send(8'h10); send(8'h20); send(8'h01);
        idle(2);
        rd_resp(8'h99);
        alu_resp(16'h0030);
        serve_tx(2, 1'b0);
        idle(2);
        chk("alu count", alu_cnt, 1);
        chk("alu fun literal", last_fun, 1);
        chk("op B addr literal", last_wr_addr, 1);
        chk("op B data literal", last_wr_data, 32'h20);
        chk("alu tx count", tx_log.size(), 3);
        chk("alu tx lo literal", tx_log[1], 32'h30);
        chk("alu tx hi literal", tx_log[2], 32'h00);

        // Junk in IDLE, then operand-less ALU frame; stray rx during tx
        send(8'h55); send(8'hFF); send(8'hDD); send(8'h03);
        idle(3);
        alu_resp(16'h1234);
        serve_tx(2, 1'b1);
        idle(2);
        chk("junk ignored wr count", wr_cnt, 3);
        chk("alu fun 3 literal", last_fun, 3);
        chk("tx lo 34 literal", tx_log[3], 32'h34);
        chk("tx hi 12 literal", tx_log[4], 32'h12);

        // Reset in OP_B, then a normal write frame
        send(8'hCC); send(8'h10);
        idle(2);
        rst = 1'b0;
        #1;
        chk("async reset outputs", 32'({bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wr_data, bus.alu_en,
                                        bus.alu_fun, bus.clk_gate_en, bus.tx_data, bus.tx_valid}), 32'd0);
        m_frame.delete();
        m_wait = 0;
        m_gate_on = 0;
        m_gate_off = 0;
        idle(2);
        rst = 1'b1;
        tick();
        send(8'hAA); send(8'h01); send(8'h11);
        idle(3);
        chk("post-reset wr count", wr_cnt, 5);
        chk("post-reset addr literal", last_wr_addr, 1);
        chk("post-reset data literal", last_wr_data, 32'h11);

        idle(3);
        chk("pending writes", exp_wr.size(), 0);
        chk("pending reads", exp_rd.size(), 0);
        chk("pending alu", exp_alu.size(), 0);
        chk("pending tx", exp_tx.size(), 0);
        chk("alu total", alu_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sys_cmd_ctrl.md
Name: sys_cmd_ctrl

Overview:
- Command-frame decoder in the reference (system) clock domain, directly downstream of the bus synchronizer on the UART-RX path.
- Consumes synchronized received bytes, each qualified by a one-cycle valid pulse, and parses fixed command frames.
- Drives register-file write/read strobes and ALU start/function, gates the ALU clock, and returns read/ALU results byte-wise to the UART-TX path with a valid/busy handshake.

Parameters:
DATA_WIDTH, 8, byte width of rx/tx/register data
ADDR_WIDTH, 4, register-file address width (low bits of address byte)
FUN_WIDTH, 4, ALU function code width (low bits of function byte)

Ports:
clk  input  1  system clock
rst  input  1  reset: rst, asynchronous, active-low
rx_data  input  DATA_WIDTH  synchronized received byte
rx_valid  input  1  single-cycle pulse, rx_data valid
rf_wr_en  output  1  register-file write strobe (1 cycle)
rf_rd_en  output  1  register-file read strobe (1 cycle)
rf_addr  output  ADDR_WIDTH  register-file address
rf_wr_data  output  DATA_WIDTH  register-file write data
rf_rd_data  input  DATA_WIDTH  register-file read data
rf_rd_valid  input  1  read data valid pulse
alu_en  output  1  ALU start strobe (1 cycle)
alu_fun  output  FUN_WIDTH  ALU function code
alu_out  input  2*DATA_WIDTH  ALU result
alu_out_valid  input  1  ALU result valid pulse
clk_gate_en  output  1  ALU clock-gate enable
tx_data  output  DATA_WIDTH  byte to transmit
tx_valid  output  1  tx_data valid, held until accepted
tx_busy  input  1  transmitter busy (already synchronized)

Behaviour:
- All outputs registered. Reset: state IDLE, every output 0, result holding register 0. Async reset mid-frame aborts the frame with no strobes.
- Frames, first byte = command:
  - 0xAA = write: addr, data.
  - 0xBB = read: addr.
  - 0xCC = ALU with operands: A, B, fun.
  - 0xDD = ALU, no operands: fun.
- IDLE: rx_valid with 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> OP_A; 0xDD -> ALU_FUN. Any other byte ignored, stays IDLE.
- WR_ADDR: on rx_valid latch rf_addr = rx_data[ADDR_WIDTH-1:0] -> WR_DATA.
- WR_DATA: on rx_valid, next cycle rf_wr_en=1 for 1 cycle with rf_wr_data=rx_data -> IDLE.
- RD_ADDR: on rx_valid, next cycle rf_rd_en=1 for 1 cycle at the latched address -> RD_WAIT.
- RD_WAIT: on rf_rd_valid latch rf_rd_data -> TX_LO (single byte; no TX_HI).
- OP_A / OP_B: on rx_valid, next cycle rf_wr_en=1 at rf_addr=0 (OP_A) or rf_addr=1 (OP_B) with the received byte. OP_A -> OP_B; OP_B -> ALU_FUN.
- ALU_FUN:
  - clk_gate_en=1 on entry.
  - On rx_valid latch alu_fun = rx_data[FUN_WIDTH-1:0]; next cycle alu_en=1 for 1 cycle -> ALU_WAIT.
- ALU_WAIT: on alu_out_valid latch alu_out; clk_gate_en falls the next cycle -> TX_LO, then TX_HI.
- TX_x:
  - tx_valid=1 with tx_data (low byte, then high byte).
  - Accepted on a cycle where tx_valid=1 and tx_busy=0; tx_valid drops the next cycle.
  - Before presenting the next byte, or returning to IDLE, wait until tx_busy has been seen 1 and then 0 after the accept.
- rx_valid outside the parse states (RD_WAIT, ALU_WAIT, TX states) is dropped; no state change.
- rf_rd_valid / alu_out_valid outside their wait states are ignored.
- Back-to-back rx_valid on consecutive cycles is handled: one byte per cycle.
- Latency: data byte rx_valid -> rf_wr_en = 1 cycle; fun byte rx_valid -> alu_en = 1 cycle.

Test Plan:
- Write frame AA,05,3C -> exactly one rf_wr_en pulse, rf_addr=5, rf_wr_data=0x3C, one cycle after the last rx_valid; state returns to IDLE.
- Read frame BB,02; rf_rd_valid with rf_rd_data=0x7E -> one rf_rd_en at addr 2; tx_valid with tx_data=0x7E held while tx_busy=1 and accepted when tx_busy=0; one byte only.
- ALU frame CC,10,20,01; alu_out=0x0030 -> writes 0x10@0 then 0x20@1; alu_en with alu_fun=1; clk_gate_en high until 1 cycle after alu_out_valid; tx bytes 0x30 then 0x00, the second presented only after a tx_busy 1->0 cycle.
- Junk bytes 55,FF in IDLE, then DD,03 -> no strobes for the junk; alu_en with fun=3; normal result TX follows.
- Extra rx_valid pulses during RD_WAIT and the TX states -> ignored; the frame still completes with correct output values.
- Assert rst in OP_B after the A byte -> all outputs 0 immediately; a subsequent AA,01,11 frame executes normally.
